multicycle_ctrl: RTL and testbench

Multi-cycle control FSM for the RV32I core. It sequences each instruction through fetch, decode, execute, memory and writeback over a shared single-port memory and a single ALU. Each cycle it drives the enables and selects for the PC, IR, register file, ALU operand muxes and the immediate generator type. It also counts retired instructions and halts on SYSTEM or illegal opcodes.

---
 rtl/multicycle_ctrl_if.sv | 38 +++
 rtl/multicycle_ctrl.sv | 178 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle sequencer and the RV32I datapath.
// The sequencer owns every output; the datapath/memory side owns the inputs.
interface multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       opcode;
  logic             branch_taken;
  logic             mem_ready;
  logic             mem_req;
  logic             mem_we;
  logic             mem_addr_sel;
  logic             ir_write;
  logic             pc_write;
  logic [1:0]       pc_src;
  logic             alu_src_a;
  logic             alu_src_b;
  logic [2:0]       imm_type;
  logic             reg_write;
  logic [1:0]       wb_sel;
  logic [2:0]       state;
  logic             halted;
  logic             illegal;
  logic [CNT_W-1:0] instret;

  modport master (
    input  opcode, branch_taken, mem_ready,
    output mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src,
           alu_src_a, alu_src_b, imm_type, reg_write, wb_sel,
           state, halted, illegal, instret
  );

  modport slave (
    output opcode, branch_taken, mem_ready,
    input  mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src,
           alu_src_a, alu_src_b, imm_type, reg_write, wb_sel,
           state, halted, illegal, instret
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I core: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB over one shared memory port and one ALU, counts
// retired instructions and halts on SYSTEM or unknown opcodes.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  multicycle_ctrl_if.master bus
);
  localparam logic [6:0] OP_ALU_R  = 7'b0110011;
  localparam logic [6:0] OP_ALU_I  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_t;

  state_t           state_q;
  logic [6:0]       opcode_q;
  logic             illegal_q;
  logic [CNT_W-1:0] instret_q;
  logic             retire;

  function automatic logic op_known(input logic [6:0] op);
    case (op)
      OP_ALU_R, OP_ALU_I, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYSTEM: op_known = 1'b1;
      default:                                      op_known = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] imm_sel(input logic [6:0] op);
    case (op)
      OP_STORE:         imm_sel = IMM_S;
      OP_BRANCH:        imm_sel = IMM_B;
      OP_LUI, OP_AUIPC: imm_sel = IMM_U;
      OP_JAL:           imm_sel = IMM_J;
      default:          imm_sel = IMM_I;
    endcase
  endfunction

  // An instruction completes in EXEC (branch), MEM (store) or WB (everything else).
  always_comb begin
    retire = 1'b0;
    case (state_q)
      S_EXEC:  retire = (opcode_q == OP_BRANCH);
      S_MEM:   retire = bus.mem_ready && (opcode_q == OP_STORE);
      S_WB:    retire = 1'b1;
      default: retire = 1'b0;
    endcase
  end

  // Sequencer state, latched opcode, sticky illegal flag and retire counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      opcode_q  <= '0;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      if (retire) instret_q <= instret_q + CNT_ONE;
      case (state_q)
        S_FETCH: if (bus.mem_ready) state_q <= S_DECODE;
        S_DECODE: begin
          opcode_q <= bus.opcode;
          if (bus.opcode == OP_SYSTEM) begin
            state_q <= S_HALT;
          end else if (!op_known(bus.opcode)) begin
            state_q   <= S_HALT;
            illegal_q <= 1'b1;
          end else begin
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (opcode_q)
            OP_BRANCH:         state_q <= S_FETCH;
            OP_LOAD, OP_STORE: state_q <= S_MEM;
            default:           state_q <= S_WB;
          endcase
        end
        S_MEM: begin
          if (bus.mem_ready) state_q <= (opcode_q == OP_STORE) ? S_FETCH : S_WB;
        end
        S_WB:    state_q <= S_FETCH;
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_FETCH;
      endcase
    end
  end

  // Per-cycle control decode from the current state and latched opcode; all
  // outputs read zero while reset is held.
  always_comb begin
    bus.mem_req      = 1'b0;
    bus.mem_we       = 1'b0;
    bus.mem_addr_sel = 1'b0;
    bus.ir_write     = 1'b0;
    bus.pc_write     = 1'b0;
    bus.pc_src       = 2'b00;
    bus.alu_src_a    = 1'b0;
    bus.alu_src_b    = 1'b0;
    bus.imm_type     = IMM_I;
    bus.reg_write    = 1'b0;
    bus.wb_sel       = 2'b00;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          bus.mem_req  = 1'b1;
          bus.ir_write = bus.mem_ready;
        end
        S_EXEC: begin
          bus.imm_type = imm_sel(opcode_q);
          case (opcode_q)
            OP_ALU_I, OP_LOAD, OP_STORE, OP_LUI, OP_JALR: bus.alu_src_b = 1'b1;
            OP_AUIPC, OP_JAL: begin
              bus.alu_src_a = 1'b1;
              bus.alu_src_b = 1'b1;
            end
            OP_BRANCH: begin
              bus.pc_write = 1'b1;
              bus.pc_src   = bus.branch_taken ? 2'b01 : 2'b00;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          bus.mem_req      = 1'b1;
          bus.mem_addr_sel = 1'b1;
          bus.mem_we       = (opcode_q == OP_STORE);
          bus.pc_write     = bus.mem_ready && (opcode_q == OP_STORE);
        end
        S_WB: begin
          // rd takes PC+4 of the pre-update PC, so both writes share this edge.
          bus.reg_write = 1'b1;
          bus.pc_write  = 1'b1;
          case (opcode_q)
            OP_LOAD:         bus.wb_sel = 2'b01;
            OP_JAL, OP_JALR: bus.wb_sel = 2'b10;
            default:         bus.wb_sel = 2'b00;
          endcase
          case (opcode_q)
            OP_JAL:  bus.pc_src = 2'b01;
            OP_JALR: bus.pc_src = 2'b10;
            default: bus.pc_src = 2'b00;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign bus.state   = rst ? 3'd0 : state_q;
  assign bus.halted  = !rst && (state_q == S_HALT);
  assign bus.illegal = !rst && illegal_q;
  assign bus.instret = rst ? '0 : instret_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed scenarios plus randomized instruction
// streams compared against a phase-list reference model.
module tb_multicycle_ctrl;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = '0;
  logic       branch_taken = 1'b0;
  logic       mem_ready = 1'b0;

  int errors = 0;
  int checks = 0;

  multicycle_ctrl_if #(.CNT_W(32)) bus ();
  multicycle_ctrl_if #(.CNT_W(4))  bus_s ();

  assign bus.opcode         = opcode;
  assign bus.branch_taken   = branch_taken;
  assign bus.mem_ready      = mem_ready;
  assign bus_s.opcode       = opcode;
  assign bus_s.branch_taken = branch_taken;
  assign bus_s.mem_ready    = mem_ready;

  multicycle_ctrl #(.CNT_W(32)) dut   (.clk(clk), .rst(rst), .bus(bus));
  multicycle_ctrl #(.CNT_W(4))  dut_s (.clk(clk), .rst(rst), .bus(bus_s));

  always #5 clk = ~clk;

  // Per-cycle trace of one instruction as observed on the DUT
  int         n_cyc;
  logic [2:0] t_state [48];
  logic       t_req   [48];
  logic       t_we    [48];
  logic       t_asel  [48];
  logic       t_irw   [48];
  logic       t_pcw   [48];
  logic       t_rw    [48];
  logic       t_rdy   [48];
  logic       t_a     [48];
  logic       t_b     [48];
  logic [1:0] t_pcsrc [48];
  logic [1:0] t_wbsel [48];
  logic [2:0] t_imm   [48];

  // Reference model output: expected state code per cycle and retire flag
  logic [2:0] exp_st[$];
  int         exp_ret;

  function automatic bit legal_op(input logic [6:0] op);
    return op inside {OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR,
                      OP_LUI, OP_AUIPC, OP_SYS};
  endfunction

  task automatic model_trace(input logic [6:0] op, input int fw, input int mw);
    exp_st.delete();
    exp_ret = 0;
    for (int i = 0; i <= fw; i++) exp_st.push_back(3'd0);
    exp_st.push_back(3'd1);
    if (op == OP_SYS || !legal_op(op)) return;
    exp_st.push_back(3'd2);
    exp_ret = 1;
    if (op == OP_BR) return;
    if (op == OP_LD || op == OP_ST)
      for (int i = 0; i <= mw; i++) exp_st.push_back(3'd3);
    if (op == OP_ST) return;
    exp_st.push_back(3'd4);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    mem_ready = 1'($urandom);
    opcode = 7'($urandom);
    @(posedge clk); #1;
    rst = 1'b0;
    mem_ready = 1'b0;
  endtask

  // Runs one instruction from FETCH: fw fetch waits, mw memory waits; inputs
  // irrelevant to the current cycle are randomized. Bounded at 40 cycles.
  task automatic exec_instr(input logic [6:0] op, input logic taken,
                            input int fw, input int mw);
    int fc, mc;
    bit left;
    fc = 0; mc = 0; left = 0; n_cyc = 0;
    while (n_cyc < 40) begin
      opcode = 7'($urandom);
      branch_taken = 1'($urandom);
      mem_ready = 1'($urandom);
      case (bus.state)
        3'd0: begin mem_ready = (fc >= fw); fc++; end
        3'd1: opcode = op;
        3'd2: branch_taken = taken;
        3'd3: begin mem_ready = (mc >= mw); mc++; end
        default: ;
      endcase
      @(negedge clk);
      t_state[n_cyc] = bus.state;     t_req[n_cyc]   = bus.mem_req;
      t_we[n_cyc]    = bus.mem_we;    t_asel[n_cyc]  = bus.mem_addr_sel;
      t_irw[n_cyc]   = bus.ir_write;  t_pcw[n_cyc]   = bus.pc_write;
      t_rw[n_cyc]    = bus.reg_write; t_rdy[n_cyc]   = mem_ready;
      t_a[n_cyc]     = bus.alu_src_a; t_b[n_cyc]     = bus.alu_src_b;
      t_pcsrc[n_cyc] = bus.pc_src;    t_wbsel[n_cyc] = bus.wb_sel;
      t_imm[n_cyc]   = bus.imm_type;
      if (bus.state != 3'd0) left = 1;
      n_cyc++;
      @(posedge clk); #1;
      if (left && (bus.state == 3'd0 || bus.state == 3'd7)) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_ready = 1'b1; opcode = OP_I; branch_taken = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.state, bus.mem_req, bus.mem_we, bus.mem_addr_sel, bus.ir_write,
         bus.pc_write, bus.pc_src, bus.alu_src_a, bus.alu_src_b, bus.imm_type,
         bus.reg_write, bus.wb_sel, bus.halted, bus.illegal} !== '0) begin
      errors++; $display("FAIL reset_outputs: got nonzero control outputs during rst");
    end
    checks++;
    if (bus.instret !== 32'd0 || bus_s.instret !== 4'd0) begin
      errors++; $display("FAIL reset_instret: got %0d/%0d want 0", bus.instret, bus_s.instret);
    end
    @(posedge clk); #1;
    rst = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.state, bus.mem_req, bus.ir_write, bus.illegal} !== {3'd0, 1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL reset_first_fetch: state=%0d mem_req=%0b want state=0 mem_req=1",
                         bus.state, bus.mem_req);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_addi();
    int bad;
    apply_reset();
    model_trace(OP_I, 0, 0);
    exec_instr(OP_I, 1'b0, 0, 0);
    checks++;
    if (n_cyc != 4) begin errors++; $display("FAIL addi_len: got %0d want 4", n_cyc); end
    bad = 0;
    for (int i = 0; i < n_cyc && i < exp_st.size(); i++) if (t_state[i] !== exp_st[i]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL addi_states: %0d cycles differ want 0", bad); end
    bad = 0;
    for (int i = 0; i < n_cyc; i++) if (t_rw[i] !== (i == 3)) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL addi_reg_write: %0d cycles wrong want 0", bad); end
    checks++;
    if ({t_imm[2], t_b[2], t_a[2]} !== {3'd0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL addi_exec: imm=%0d b=%0b a=%0b want 0 1 0", t_imm[2], t_b[2], t_a[2]);
    end
    checks++;
    if (bus.instret !== 32'd1) begin errors++; $display("FAIL addi_instret: got %0d want 1", bus.instret); end
  endtask

  task automatic test_load();
    int bad;
    apply_reset();
    exec_instr(OP_LD, 1'b0, 0, 2);
    checks++;
    if (n_cyc != 7) begin errors++; $display("FAIL lw_len: got %0d want 7", n_cyc); end
    bad = 0;
    for (int i = 3; i <= 5; i++)
      if ({t_state[i], t_req[i], t_we[i], t_asel[i]} !== {3'd3, 1'b1, 1'b0, 1'b1}) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL lw_mem_phase: %0d cycles wrong want 0", bad); end
    checks++;
    if ({t_state[6], t_wbsel[6], t_rw[6], t_pcw[6]} !== {3'd4, 2'b01, 1'b1, 1'b1}) begin
      errors++; $display("FAIL lw_wb: state=%0d wb_sel=%0d rw=%0b pcw=%0b want 4 1 1 1",
                         t_state[6], t_wbsel[6], t_rw[6], t_pcw[6]);
    end
    checks++;
    if (bus.instret !== 32'd1) begin errors++; $display("FAIL lw_instret: got %0d want 1", bus.instret); end
  endtask

  task automatic test_branch();
    int bad;
    apply_reset();
    for (int k = 0; k < 2; k++) begin
      exec_instr(OP_BR, (k == 0), 0, 0);
      checks++;
      if (n_cyc != 3) begin errors++; $display("FAIL br%0d_len: got %0d want 3", k, n_cyc); end
      checks++;
      if ({t_pcw[2], t_pcsrc[2], t_imm[2]} !== {1'b1, (k == 0) ? 2'b01 : 2'b00, 3'd2}) begin
        errors++; $display("FAIL br%0d_exec: pcw=%0b pc_src=%0d imm=%0d want 1 %0d 2",
                           k, t_pcw[2], t_pcsrc[2], t_imm[2], (k == 0) ? 1 : 0);
      end
      bad = 0;
      for (int i = 0; i < n_cyc; i++) if (t_rw[i] !== 1'b0) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL br%0d_no_rw: %0d reg_write cycles want 0", k, bad); end
    end
    checks++;
    if (bus.instret !== 32'd2) begin errors++; $display("FAIL br_instret: got %0d want 2", bus.instret); end
  endtask

  task automatic test_jumps_store();
    int bad;
    apply_reset();
    exec_instr(OP_JALR, 1'b0, 0, 0);
    checks++;
    if ({t_wbsel[3], t_pcsrc[3], t_imm[2], t_rw[3]} !== {2'b10, 2'b10, 3'd0, 1'b1}) begin
      errors++; $display("FAIL jalr: wb_sel=%0d pc_src=%0d imm=%0d want 2 2 0", t_wbsel[3], t_pcsrc[3], t_imm[2]);
    end
    exec_instr(OP_JAL, 1'b0, 0, 0);
    checks++;
    if ({t_wbsel[3], t_pcsrc[3], t_imm[2]} !== {2'b10, 2'b01, 3'd4}) begin
      errors++; $display("FAIL jal: wb_sel=%0d pc_src=%0d imm=%0d want 2 1 4", t_wbsel[3], t_pcsrc[3], t_imm[2]);
    end
    exec_instr(OP_AUIPC, 1'b0, 0, 0);
    checks++;
    if ({t_a[2], t_b[2], t_imm[2], t_wbsel[3]} !== {1'b1, 1'b1, 3'd3, 2'b00}) begin
      errors++; $display("FAIL auipc: a=%0b b=%0b imm=%0d want 1 1 3", t_a[2], t_b[2], t_imm[2]);
    end
    exec_instr(OP_ST, 1'b0, 1, 0);
    checks++;
    if (n_cyc != 5) begin errors++; $display("FAIL sw_len: got %0d want 5", n_cyc); end
    checks++;
    if ({t_state[4], t_we[4], t_asel[4], t_pcw[4], t_pcsrc[4], t_imm[3]} !==
        {3'd3, 1'b1, 1'b1, 1'b1, 2'b00, 3'd1}) begin
      errors++; $display("FAIL sw_mem: state=%0d we=%0b asel=%0b pcw=%0b imm=%0d want 3 1 1 1 1",
                         t_state[4], t_we[4], t_asel[4], t_pcw[4], t_imm[3]);
    end
    bad = 0;
    for (int i = 0; i < n_cyc; i++) if (t_rw[i] !== 1'b0) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL sw_no_rw: %0d reg_write cycles want 0", bad); end
    checks++;
    if (bus.instret !== 32'd4) begin errors++; $display("FAIL jump_store_instret: got %0d want 4", bus.instret); end
  endtask

  task automatic test_halt();
    int bad;
    logic [31:0] held;
    apply_reset();
    exec_instr(OP_I, 1'b0, 0, 0);
    exec_instr(7'b0000000, 1'b0, 0, 0);
    checks++;
    if ({bus.state, bus.halted, bus.illegal, bus.mem_req} !== {3'd7, 1'b1, 1'b1, 1'b0}) begin
      errors++; $display("FAIL halt_illegal: state=%0d halted=%0b illegal=%0b want 7 1 1",
                         bus.state, bus.halted, bus.illegal);
    end
    held = bus.instret;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      mem_ready = (i % 2 == 0); opcode = 7'($urandom); branch_taken = 1'($urandom);
      @(negedge clk);
      if ({bus.state, bus.mem_req, bus.ir_write, bus.pc_write, bus.reg_write, bus.mem_we, bus.illegal} !==
          {3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL halt_absorbing: %0d cycles wrong want 0", bad); end
    checks++;
    if (bus.instret !== 32'd1 || held !== 32'd1) begin
      errors++; $display("FAIL halt_instret: got %0d want 1", bus.instret);
    end
    apply_reset();
    @(negedge clk);
    checks++;
    if ({bus.state, bus.illegal, bus.halted, bus.mem_req} !== {3'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL halt_reset: state=%0d illegal=%0b want 0 0", bus.state, bus.illegal);
    end
    @(posedge clk); #1;
    exec_instr(OP_SYS, 1'b0, 0, 0);
    checks++;
    if ({bus.state, bus.halted, bus.illegal, bus.instret} !== {3'd7, 1'b1, 1'b0, 32'd0}) begin
      errors++; $display("FAIL halt_system: state=%0d illegal=%0b instret=%0d want 7 0 0",
                         bus.state, bus.illegal, bus.instret);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      exec_instr(OP_I, 1'b0, 0, 0);
      if (i == 14) begin
        checks++;
        if (bus_s.instret !== 4'd15) begin errors++; $display("FAIL wrap_15: got %0d want 15", bus_s.instret); end
      end
    end
    checks++;
    if (bus_s.instret !== 4'd0 || bus.instret !== 32'd16) begin
      errors++; $display("FAIL wrap_16: got %0d/%0d want 0/16", bus_s.instret, bus.instret);
    end
  endtask

  task automatic test_abort();
    apply_reset();
    exec_instr(OP_I, 1'b0, 0, 0);
    mem_ready = 1'b1; opcode = 7'($urandom);
    @(posedge clk); #1;
    opcode = OP_R;
    @(posedge clk); #1;
    checks++;
    if (bus.state !== 3'd2) begin errors++; $display("FAIL abort_in_exec: state=%0d want 2", bus.state); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.state, bus.pc_write, bus.reg_write, bus.mem_req, bus.instret} !== '0) begin
      errors++; $display("FAIL abort_rst_outputs: state=%0d instret=%0d want 0 0", bus.state, bus.instret);
    end
    @(posedge clk); #1;
    rst = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.state, bus.mem_req, bus.instret} !== {3'd0, 1'b1, 32'd0}) begin
      errors++; $display("FAIL abort_after: state=%0d mem_req=%0b instret=%0d want 0 1 0",
                         bus.state, bus.mem_req, bus.instret);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [6:0] ops [9];
    logic [6:0] op;
    int fw, mw, bad, exp_cnt;
    logic st_bad, rdy;
    ops = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    apply_reset();
    exp_cnt = 0;
    for (int k = 0; k < 60; k++) begin
      op = ops[$urandom_range(0, 8)];
      fw = $urandom_range(0, 3);
      mw = $urandom_range(0, 3);
      model_trace(op, fw, mw);
      exec_instr(op, 1'($urandom), fw, mw);
      exp_cnt += exp_ret;
      checks++;
      if (n_cyc != exp_st.size()) begin
        errors++; $display("FAIL rand%0d_len: op=%b got %0d want %0d", k, op, n_cyc, exp_st.size());
      end
      bad = 0;
      for (int i = 0; i < n_cyc && i < exp_st.size(); i++) begin
        rdy = t_rdy[i];
        st_bad = (t_state[i] !== exp_st[i]) ||
                 (t_req[i] !== (exp_st[i] == 3'd0 || exp_st[i] == 3'd3)) ||
                 (t_rw[i]  !== (exp_st[i] == 3'd4)) ||
                 (t_irw[i] !== (exp_st[i] == 3'd0 && rdy)) ||
                 (t_we[i]  !== (exp_st[i] == 3'd3 && op == OP_ST)) ||
                 (t_pcw[i] !== ((exp_st[i] == 3'd4) || (exp_st[i] == 3'd2 && op == OP_BR) ||
                                (exp_st[i] == 3'd3 && op == OP_ST && rdy)));
        if (st_bad) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL rand%0d_trace: op=%b %0d cycles wrong want 0", k, op, bad); end
      checks++;
      if (bus.instret !== 32'(exp_cnt) || bus_s.instret !== 4'(exp_cnt)) begin
        errors++; $display("FAIL rand%0d_instret: got %0d/%0d want %0d", k, bus.instret, bus_s.instret, exp_cnt);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_addi();
    test_load();
    test_branch();
    test_jumps_store();
    test_halt();
    test_wrap();
    test_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
